// File: rtl/mmu_sram_bridge_pkg.sv
// Shared constants and FSM encoding for the 64-bit host to 16-bit SRAM bridge.
package mmu_sram_bridge_pkg;
  localparam int BEATS   = 4;
  localparam int BEAT_W  = 2;
  localparam int HOST_DW = 64;
  localparam int SRAM_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_TAIL = 2'd2
  } state_e;
endpackage

// File: rtl/mmu_sram_bridge.sv
// Splits one 64-bit host access into four 16-bit SRAM beats plus a tail cycle
// that collects the last read word, then pulses done.
module mmu_sram_bridge
  import mmu_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                be7n,
  input  logic                be6n,
  input  logic                be5n,
  input  logic                be4n,
  input  logic                be3n,
  input  logic                be2n,
  input  logic                be1n,
  input  logic                be0n,
  input  logic [HOST_DW-1:0]  data_in,
  output logic [HOST_DW-1:0]  data_out,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-2:0]   sram_addr,
  output logic                sram_en,
  output logic                sram_we,
  output logic [1:0]          sram_be_n,
  output logic [SRAM_DW-1:0]  sram_wdata,
  input  logic [SRAM_DW-1:0]  sram_rdata,
  output state_e              dbg_state,
  output logic [BEAT_W-1:0]   dbg_beat
);

  state_e                     state_q, state_d;
  logic [BEAT_W-1:0]          beat_q, beat_d;
  logic [ADDR_W-4:0]          waddr_q, waddr_d;
  logic                       we_q, we_d;
  logic [HOST_DW-1:0]         data_q, data_d;
  logic [7:0]                 ben_q, ben_d;
  logic [3*SRAM_DW-1:0]       rbuf_q, rbuf_d;
  logic [HOST_DW-1:0]         dout_q, dout_d;
  logic                       done_q, done_d;
  logic [1:0]                 lanes_n;
  logic                       unused_addr_lsb;

  assign unused_addr_lsb = ^addr[2:0];

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    waddr_d = waddr_q;
    we_d    = we_q;
    data_d  = data_q;
    ben_d   = ben_q;
    rbuf_d  = rbuf_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          waddr_d = addr[ADDR_W-1:3];
          we_d    = we;
          data_d  = data_in;
          ben_d   = {be7n, be6n, be5n, be4n, be3n, be2n, be1n, be0n};
          beat_d  = '0;
          state_d = ST_BEAT;
        end
      end
      ST_BEAT: begin
        // SRAM returns the previous beat's word; shift it in from the top.
        if (!we_q && beat_q != '0)
          rbuf_d = {sram_rdata, rbuf_q[3*SRAM_DW-1:SRAM_DW]};
        if (beat_q == BEAT_W'(BEATS - 1)) state_d = ST_TAIL;
        else                               beat_d  = beat_q + 1'b1;
      end
      ST_TAIL: begin
        if (!we_q) dout_d = {sram_rdata, rbuf_q};
        beat_d  = '0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lanes_n    = {ben_q[{beat_q, 1'b1}], ben_q[{beat_q, 1'b0}]};
    sram_en    = (state_q == ST_BEAT);
    sram_addr  = {waddr_q, beat_q};
    sram_wdata = data_q[{beat_q, 4'b0000} +: SRAM_DW];
    sram_we    = 1'b0;
    sram_be_n  = 2'b11;
    if (sram_en) begin
      sram_we   = we_q && (lanes_n != 2'b11);
      sram_be_n = we_q ? lanes_n : 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      ben_q   <= 8'hFF;
      rbuf_q  <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
      data_q  <= data_d;
      ben_q   <= ben_d;
      rbuf_q  <= rbuf_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  assign data_out  = dout_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;
  assign dbg_beat  = beat_q;

endmodule

// File: doc/mmu_sram_bridge.md
MMU_SRAM_BRIDGE -- requirements
Module: mmu_sram_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: host byte-address width.
REQ-002 SHALL have a single clock and a synchronous, active-high reset.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1: host request strobe.
REQ-006 SHALL have port we, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have port addr, input, ADDR_W: byte address; addr[2:0] ignored (8-byte aligned).
REQ-008 SHALL have ports be7n..be0n, input, 1 each: active-low byte enables; bytes map little-endian to data_in[8k+7:8k].
REQ-009 SHALL have port data_in, input, 64: write data.
REQ-010 SHALL have port data_out, output, 64: read data.
REQ-011 SHALL have port busy, output, 1: a request is in progress.
REQ-012 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port sram_addr, output, ADDR_W-1: 16-bit word address.
REQ-014 SHALL have port sram_en, output, 1: SRAM access strobe.
REQ-015 SHALL have port sram_we, output, 1: SRAM write strobe.
REQ-016 SHALL have port sram_be_n, output, 2: active-low lane enables; [1] = upper byte, [0] = lower byte.
REQ-017 SHALL have port sram_wdata, output, 16: SRAM write data.
REQ-018 SHALL have port sram_rdata, input, 16: SRAM read data, valid one cycle after a read beat.

Function
REQ-019 The FSM SHALL have states IDLE, BEAT (2-bit beat counter 0..3) and TAIL.
REQ-020 In IDLE with en=1, the block SHALL latch addr, we, data_in and all be*n on the clock edge and enter BEAT with beat=0.
REQ-021 Beats SHALL occur in request cycles 1..4, where cycle 0 is the cycle en is sampled.
REQ-022 Each beat SHALL drive sram_en=1.
REQ-023 Each beat SHALL drive sram_addr={addr[ADDR_W-1:3], beat}.
REQ-024 Each beat SHALL drive sram_wdata=data[16*beat+15:16*beat].
REQ-025 On writes, sram_be_n SHALL be {be(2*beat+1)n, be(2*beat)n}, and sram_we SHALL be 1 only if at least one lane is enabled.
REQ-026 On writes, a beat with both lanes disabled SHALL still consume its cycle with sram_we=0.
REQ-027 On reads, sram_be_n SHALL be 2'b00 and sram_we SHALL be 0; host byte enables SHALL be ignored and all 64 bits returned.
REQ-028 During a read, sram_rdata SHALL be captured in cycles 2..5 into data_out slices [15:0], [31:16], [47:32] and [63:48] respectively.
REQ-029 data_out SHALL update only at the end of a read, holding its previous value throughout a read, and SHALL be unchanged by writes.
REQ-030 TAIL SHALL occupy cycle 5 with sram_en=0; the FSM SHALL then return to IDLE.
REQ-031 done SHALL be 1 in cycle 6 only; busy SHALL be 1 in cycles 1..5 only.
REQ-032 en sampled in cycle 6 SHALL be accepted, giving a back-to-back period of 6 cycles.
REQ-033 en while busy=1 SHALL be ignored; requests are not queued.
REQ-034 Outside beats, sram_en and sram_we SHALL be 0 and sram_be_n SHALL be 2'b11.

Reset
REQ-035 With reset=1 at a clock edge, the block SHALL enter IDLE, and the following cycle SHALL show busy=0, done=0, data_out=0, sram_en=0, sram_we=0, sram_be_n=2'b11 and beat=0.
REQ-036 Reset mid-request SHALL abort the request with no further SRAM strobes and no done pulse.
REQ-037 en SHALL be ignored while reset=1.

Structure
REQ-038 A shared package SHALL hold the state encodings, BEATS=4, BEAT_W=2, HOST_DW=64 and SRAM_DW=16.
REQ-039 The RTL SHALL be a single module with no sub-module; the bench SHALL use a separate 16-bit synchronous SRAM model, sram16_model, with 1-cycle read latency.

Verification
REQ-040 Full write then read: write 0xDEADBEEFBAADC0DE to addr 0x08 with all be*n=0, then read 0x08 -> write beats wdata C0DE, BAAD, BEEF, DEAD at word addresses 4..7; read data_out=0xDEADBEEFBAADC0DE with done in cycle 6.
REQ-041 Partial write: prefill addr 0x10 with 0, write 0xFFFFFFFFFFFFFFFF with only be0n=0 and be7n=0, then read -> data_out=0xFF000000000000FF; beats 1 and 2 show sram_we=0.
REQ-042 Back-to-back: 16 writes of 0xDEADBEEFBAADC0DE to addrs i*8 (i=0..15), each issued in its done cycle -> each completes exactly 6 cycles apart; readback of every address is correct.
REQ-043 Busy rejection: pulse en with addr 0x20 in cycle 3 of a write to 0x18 -> only the 0x18 request executes; exactly one done pulse.
REQ-044 Reset abort: assert reset in cycle 2 of a write -> no sram_en after reset; done stays 0; busy=0 and data_out=0 in the following cycle.
REQ-045 Misaligned address: write to addr 0x0F -> behaves identically to a write to addr 0x08.
